// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter -- round-robin Wishbone classic arbiter, NM masters onto one
// slave port. Ownership is registered, granted one cycle after CYC is seen
// in IDLE, and held until the owner drops CYC. A per-transfer watchdog
// answers a stalled STB with ERR after TIMEOUT cycles (TIMEOUT=0 disables it).
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   i_mcyc/i_mstb/i_mwe [NM]     per-master Wishbone control
//   i_maddr/i_mdata/i_msel       per-master packed address/write data/select
//   o_mack/o_merr [NM]           per-master ACK/ERR (owner only)
//   o_mdata [NM*DW]              slave read data replicated to every master
//   o_scyc..o_ssel               slave-side request, muxed from the owner
//   i_sack/i_serr/i_sdata        slave response
//   o_grant [NM]                 registered one-hot owner, zero when idle
module wb_rr_arbiter #(
  parameter int NM      = 2,
  parameter int AW      = 22,
  parameter int DW      = 32,
  parameter int SW      = 4,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NM-1:0]    i_mcyc,
  input  logic [NM-1:0]    i_mstb,
  input  logic [NM-1:0]    i_mwe,
  input  logic [NM*AW-1:0] i_maddr,
  input  logic [NM*DW-1:0] i_mdata,
  input  logic [NM*SW-1:0] i_msel,
  output logic [NM-1:0]    o_mack,
  output logic [NM-1:0]    o_merr,
  output logic [NM*DW-1:0] o_mdata,
  output logic             o_scyc,
  output logic             o_sstb,
  output logic             o_swe,
  output logic [AW-1:0]    o_saddr,
  output logic [DW-1:0]    o_sdata,
  output logic [SW-1:0]    o_ssel,
  input  logic             i_sack,
  input  logic             i_serr,
  input  logic [DW-1:0]    i_sdata,
  output logic [NM-1:0]    o_grant
);

  localparam int LW = $clog2(NM);
  localparam int WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic {IDLE, OWN} state_e;

  state_e          state_q, state_d;
  logic [NM-1:0]   grant_q, grant_d;
  logic [LW-1:0]   gidx_q,  gidx_d;
  logic [LW-1:0]   last_q,  last_d;
  logic [WW-1:0]   wdog_q,  wdog_d;

  logic            own, gcyc, gstb, to_fire;
  logic            pick_vld;
  logic [LW-1:0]   pick;
  logic [LW:0]     idx;

  // Unpacked per-master views so the owner mux is a plain array select.
  logic [AW-1:0]   maddr_a [NM];
  logic [DW-1:0]   mdata_a [NM];
  logic [SW-1:0]   msel_a  [NM];

  for (genvar k = 0; k < NM; k++) begin : g_view
    assign maddr_a[k]           = i_maddr[k*AW +: AW];
    assign mdata_a[k]           = i_mdata[k*DW +: DW];
    assign msel_a[k]            = i_msel[k*SW +: SW];
    assign o_mdata[k*DW +: DW]  = rst ? '0 : i_sdata;
  end

  assign own  = (state_q == OWN);
  assign gcyc = i_mcyc[gidx_q];
  assign gstb = i_mstb[gidx_q];

  // Round-robin search upward from last+1. Iterating from the farthest
  // candidate down lets the nearest requester overwrite earlier hits.
  always_comb begin
    pick_vld = 1'b0;
    pick     = last_q;
    idx      = '0;
    for (int i = NM; i >= 1; i--) begin
      idx = {1'b0, last_q} + (LW+1)'(i);
      if (idx >= (LW+1)'(NM)) idx = idx - (LW+1)'(NM);
      if (i_mcyc[idx[LW-1:0]]) begin
        pick_vld = 1'b1;
        pick     = idx[LW-1:0];
      end
    end
  end

  // Watchdog fires while the owner is still strobing and the count has hit
  // the limit; the same cycle suppresses STB so the slave sees the abort.
  assign to_fire = (TIMEOUT > 0) && own && gcyc && gstb &&
                   (wdog_q == WW'(TIMEOUT));

  // Slave side: combinational from the owner, forced low outside OWN.
  assign o_scyc  = own & gcyc;
  assign o_sstb  = own & gcyc & gstb & ~to_fire;
  assign o_swe   = own & i_mwe[gidx_q];
  assign o_saddr = own ? maddr_a[gidx_q] : '0;
  assign o_sdata = own ? mdata_a[gidx_q] : '0;
  assign o_ssel  = own ? msel_a[gidx_q]  : '0;

  // grant_q is only non-zero in OWN, so it doubles as the response steer.
  // ERR beats ACK when the slave asserts both.
  assign o_mack  = grant_q & i_mcyc & {NM{i_sack & ~i_serr}};
  assign o_merr  = grant_q & i_mcyc & {NM{i_serr | to_fire}};
  assign o_grant = grant_q;

  always_comb begin
    wdog_d = '0;
    if ((TIMEOUT > 0) && o_sstb && !i_sack && !i_serr)
      wdog_d = wdog_q + WW'(1);
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d = OWN;
          grant_d = {{(NM-1){1'b0}}, 1'b1} << pick;
          gidx_d  = pick;
          last_d  = pick;
        end
      end
      OWN: begin
        if (!gcyc) begin
          state_d = IDLE;
          grant_d = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      last_q  <= LW'(NM - 1);
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      last_q  <= last_d;
      wdog_q  <= wdog_d;
    end
  end

endmodule
